// File: rtl/sap2_pkg.sv
// Shared SAP-2 definitions.
//   SAP2_ADDR_W     : address / program counter width
//   SAP2_RESET_ADDR : program start address
//   jk_cmd_t        : {J,K} excitation pair for a JK cell, with named commands
package sap2_pkg;

  localparam int unsigned    SAP2_ADDR_W     = 16;
  localparam logic [15:0]    SAP2_RESET_ADDR = 16'h0000;

  typedef struct packed {
    logic j;
    logic k;
  } jk_cmd_t;

  localparam jk_cmd_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
  localparam jk_cmd_t JK_RESET  = '{j: 1'b0, k: 1'b1};
  localparam jk_cmd_t JK_SET    = '{j: 1'b1, k: 1'b0};
  localparam jk_cmd_t JK_TOGGLE = '{j: 1'b1, k: 1'b1};

endpackage

// File: rtl/sap2_jk_cell.sv
// Single falling-edge JK flip-flop with synchronous active-high reset.
//   iClk   : clock, state changes on the falling edge
//   iReset : synchronous reset to INIT (wins over J/K)
//   iJ, iK : excitation (00 hold, 01 reset, 10 set, 11 toggle)
//   oQ     : stored bit
//   oQBar  : always ~oQ
module sap2_jk_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iJ,
  input  logic iK,
  output logic oQ,
  output logic oQBar
);

  logic q = INIT;

  always_ff @(negedge iClk) begin
    if (iReset) begin
      q <= INIT;
    end else begin
      case ({iJ, iK})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign oQ    = q;
  assign oQBar = ~q;

endmodule

// File: rtl/sap2_program_counter_jk.sv
// SAP-2 program counter built from an array of falling-edge JK cells.
//   iClk       : clock, all updates on the falling edge
//   iReset     : synchronous active-high reset to RESET_VALUE, clears oWrap
//   iLoad      : load iLoadData (JMP/CALL/RET), wins over iCount
//   iLoadData  : value to load
//   iCount     : increment by one (synchronous carry)
//   iOutEnable : gate oQ onto the W-bus
//   oQ         : current count
//   oBusData   : oQ when iOutEnable, else zero (OR-bus)
//   oWrap      : one-cycle pulse after a count from all-ones to zero
module sap2_program_counter_jk
  import sap2_pkg::*;
#(
  parameter int unsigned       WIDTH       = SAP2_ADDR_W,
  parameter logic [WIDTH-1:0]  RESET_VALUE = SAP2_RESET_ADDR
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadData,
  input  logic             iCount,
  input  logic             iOutEnable,
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oBusData,
  output logic             oWrap
);

  jk_cmd_t [WIDTH-1:0] jkCmd;
  logic    [WIDTH-1:0] q;
  logic    [WIDTH-1:0] qBar;
  logic                carry;
  logic                allOnes;
  logic                wrapNext;
  logic                wrapReg = 1'b0;

  // Excitation: load forces each bit via set/reset; count toggles bit i
  // when every lower bit is one (carry ANDed bit by bit, not rippled
  // through the flops, so all bits move on the same edge).
  always_comb begin
    jkCmd = '0;
    carry = 1'b1;
    if (iLoad) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        jkCmd[i] = iLoadData[i] ? JK_SET : JK_RESET;
      end
    end else if (iCount) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (carry) begin
          jkCmd[i] = JK_TOGGLE;
        end
        carry = carry & q[i];
      end
    end
  end

  assign allOnes  = ~|qBar;
  assign wrapNext = iCount & ~iLoad & allOnes;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : gCell
    sap2_jk_cell #(
      .INIT (RESET_VALUE[g])
    ) uCell (
      .iClk   (iClk),
      .iReset (iReset),
      .iJ     (jkCmd[g].j),
      .iK     (jkCmd[g].k),
      .oQ     (q[g]),
      .oQBar  (qBar[g])
    );
  end

  always_ff @(negedge iClk) begin
    if (iReset) begin
      wrapReg <= 1'b0;
    end else begin
      wrapReg <= wrapNext;
    end
  end

  assign oQ       = q;
  assign oWrap    = wrapReg;
  assign oBusData = iOutEnable ? q : '0;

endmodule

// File: tb/tb_sap2_program_counter_jk.sv
module tb_sap2_program_counter_jk;

  logic        iClk = 1'b0;
  logic        iReset = 1'b0;
  logic        iLoad = 1'b0;
  logic [15:0] iLoadData = '0;
  logic        iCount = 1'b0;
  logic        iOutEnable = 1'b0;
  logic [15:0] oQ;
  logic [15:0] oBusData;
  logic        oWrap;

  sap2_program_counter_jk #(
    .WIDTH       (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iLoad      (iLoad),
    .iLoadData  (iLoadData),
    .iCount     (iCount),
    .iOutEnable (iOutEnable),
    .oQ         (oQ),
    .oBusData   (oBusData),
    .oWrap      (oWrap)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [15:0] q;
    logic        wrap;
    logic        oe;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   model = 0;   // reference count as a plain integer
  bit   stimDone = 0;

  // One cycle of stimulus: drive after the rising edge, predict the state
  // that the following falling edge must produce.
  task automatic step(input bit rst, input bit ld, input logic [15:0] data,
                      input bit cnt, input bit oe, input string tag);
    exp_t e;
    bit   w;
    @(posedge iClk);
    #1;
    iReset = rst; iLoad = ld; iLoadData = data; iCount = cnt; iOutEnable = oe;
    w = 0;
    if (rst)       model = 0;
    else if (ld)   model = int'(data);
    else if (cnt) begin
      w = (model == 65535);
      model = (model + 1) % 65536;
    end
    e.q = model[15:0]; e.wrap = w; e.oe = oe; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: the state settles on the falling edge; sample on the rising edge
  // while the inputs of that cycle are still applied.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check({e.tag, ".q"},    oQ,              e.q);
        check({e.tag, ".wrap"}, {15'd0, oWrap},  {15'd0, e.wrap});
        check({e.tag, ".bus"},  oBusData,        e.oe ? e.q : 16'h0000);
      end
    end
  end

  initial begin
    logic [15:0] d;
    int          r;
    // 1. reset wins over load
    step(1, 1, 16'h1234, 0, 0, "reset");
    // 2. count 1..5 then hold
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 1, 1, "count");
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 1, "hold");
    // 3. carry chain
    step(0, 1, 16'h00FF, 0, 0, "ld00FF");
    step(0, 0, 16'h0,    1, 0, "carry0100");
    step(0, 1, 16'h7FFF, 0, 0, "ld7FFF");
    step(0, 0, 16'h0,    1, 0, "carry8000");
    // 4. wrap then next count
    step(0, 1, 16'hFFFF, 0, 0, "ldFFFF");
    step(0, 0, 16'h0,    1, 0, "wrap");
    step(0, 0, 16'h0,    1, 0, "afterwrap");
    // 5. priority
    step(0, 1, 16'hABCD, 1, 1, "loadWinsCount");
    step(0, 1, 16'h0010, 0, 0, "ld0010");
    step(1, 0, 16'h0,    1, 0, "resetWinsCount");
    // 6. bus gating, mid-count reset
    step(0, 1, 16'h0042, 0, 0, "ld0042");
    step(0, 0, 16'h0,    0, 0, "busOff");
    step(0, 0, 16'h0,    0, 1, "busOn");
    step(0, 0, 16'h0,    1, 1, "cnt");
    step(0, 0, 16'h0,    1, 1, "cnt");
    step(1, 0, 16'h0,    1, 1, "midReset");
    step(0, 0, 16'h0,    1, 1, "countAfterReset");
    // Random traffic, biased towards the top of the range to hit wraps.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      d = (r == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), d,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rand");
    end
    stimDone = 1;
  end

  initial begin
    int cycles = 0;
    wait (stimDone);
    while (expQ.size() != 0 && cycles < 10) begin
      @(negedge iClk);
      cycles++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached, required finish");
    $fatal(1);
  end

endmodule
